// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the RV pipeline stage registers: stage FSM state,
// packed inter-stage payload layouts and their widths.
package rv_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [3:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc_plus4;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;
    ctrl_t             ctrl;
  } id_ex_t;

  typedef struct packed {
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   store_data;
    logic [XLEN-1:0]   pc_plus4;
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;
    ctrl_t             ctrl;
  } ex_mem_t;

  typedef struct packed {
    logic [XLEN-1:0]   wb_data;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
  } mem_wb_t;

  localparam int unsigned ID_EX_W  = $bits(id_ex_t);
  localparam int unsigned EX_MEM_W = $bits(ex_mem_t);
  localparam int unsigned MEM_WB_W = $bits(mem_wb_t);

  function automatic logic [1:0] occ_of(pipe_state_e s);
    case (s)
      BUSY:    return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline stage register with flush and a
// saturating count of entries discarded by flush.
module pipe_stage_reg
  import rv_pipe_pkg::*;
#(
  parameter int unsigned        DATA_W     = 32,
  parameter logic [DATA_W-1:0]  FLUSH_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [7:0]        flush_drops
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [7:0]        drops_q, drops_d;
  logic              in_fire, out_fire;
  logic [1:0]        drop_add;
  logic [8:0]        drop_sum;

  // Handshake outputs depend on registered state only.
  assign out_valid   = (state_q != EMPTY);
  assign in_ready    = (state_q != FULL);
  assign occupancy   = occ_of(state_q);
  assign out_data    = main_q;
  assign flush_drops = drops_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = FLUSH_DATA;
      skid_d  = FLUSH_DATA;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = BUSY;
            main_d  = in_data;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = BUSY;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // An entry leaving downstream on the flush edge was delivered, not dropped.
  always_comb begin
    drop_add = occupancy - {1'b0, out_fire};
    drop_sum = {1'b0, drops_q} + {7'd0, drop_add};
    drops_d  = drops_q;
    if (flush) begin
      drops_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= FLUSH_DATA;
      skid_q  <= FLUSH_DATA;
      drops_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      drops_q <= drops_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized and directed bench for pipe_stage_reg against a queue-based
// model of the stage's FIFO, flush and drop-count rules.
module tb_pipe_stage_reg;

  localparam int unsigned W = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [1:0]    occupancy;
  logic [7:0]    flush_drops;

  pipe_stage_reg #(.DATA_W(W), .FLUSH_DATA(16'h0000)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .flush_drops(flush_drops)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit started  = 1'b0;

  // Model: queue of live entries, drop counter, and whether main is known
  // to hold FLUSH_DATA (after reset/flush, before any new entry).
  logic [W-1:0] mq[$];
  int           mdrops = 0;
  bit           mclean = 1'b1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  always @(posedge clk) begin
    automatic int sz   = mq.size();
    automatic bit in_f = in_valid && (sz < 2);
    automatic bit out_f = out_ready && (sz > 0);
    if (reset) begin
      mq.delete();
      mdrops = 0;
      mclean = 1'b1;
    end else if (flush) begin
      mdrops = mdrops + sz - (out_f ? 1 : 0);
      if (mdrops > 255) mdrops = 255;
      mq.delete();
      mclean = 1'b1;
    end else begin
      if (out_f) void'(mq.pop_front());
      if (in_f) begin
        mq.push_back(in_data);
        mclean = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      check("in_ready", 32'(in_ready), 32'(mq.size() < 2));
      check("occupancy", 32'(occupancy), 32'(mq.size()));
      check("flush_drops", 32'(flush_drops), 32'(mdrops));
      if (mq.size() > 0) check("out_data", 32'(out_data), 32'(mq[0]));
      else if (mclean) check("out_data_flushval", 32'(out_data), 32'h0);
    end
  end

  // Apply inputs for one cycle; returns #1 after the capturing edge.
  task automatic cyc(input bit v, input logic [W-1:0] d, input bit r, input bit f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    reset = 1'b1;
    cyc(0, '0, 0, 0);
    cyc(1, 16'hDEAD, 1, 1);
    reset = 1'b0;
    started = 1'b1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_drops", 32'(flush_drops), 32'd0);

    // Streaming
    cyc(1, 16'h11, 1, 0);
    check("str_11", 32'(out_data), 32'h11);
    check("str_occ", 32'(occupancy), 32'd1);
    cyc(1, 16'h22, 1, 0);
    check("str_22", 32'(out_data), 32'h22);
    cyc(1, 16'h33, 1, 0);
    check("str_33", 32'(out_data), 32'h33);
    check("str_occ3", 32'(occupancy), 32'd1);
    cyc(0, '0, 1, 0);
    check("str_drain", 32'(out_valid), 32'd0);

    // Stall into skid
    cyc(1, 16'hA1, 1, 0);
    cyc(1, 16'hB2, 0, 0);
    check("stall_occ", 32'(occupancy), 32'd2);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_head", 32'(out_data), 32'hA1);
    cyc(1, 16'hC3, 0, 0);
    check("stall_hold", 32'(out_data), 32'hA1);
    cyc(0, '0, 1, 0);
    check("stall_second", 32'(out_data), 32'hB2);
    check("stall_occ1", 32'(occupancy), 32'd1);
    cyc(0, '0, 1, 0);
    check("stall_empty", 32'(out_valid), 32'd0);

    // Flush when FULL
    cyc(1, 16'hA1, 0, 0);
    cyc(1, 16'hB2, 0, 0);
    cyc(0, '0, 0, 1);
    check("flfull_valid", 32'(out_valid), 32'd0);
    check("flfull_data", 32'(out_data), 32'h0);
    check("flfull_drops", 32'(flush_drops), 32'd2);

    // Flush with out and in transfer in BUSY
    cyc(1, 16'h55, 0, 0);
    cyc(1, 16'h66, 1, 1);
    check("flbusy_valid", 32'(out_valid), 32'd0);
    check("flbusy_drops", 32'(flush_drops), 32'd2);
    cyc(0, '0, 1, 0);
    check("flbusy_lost", 32'(out_valid), 32'd0);

    // Saturation
    for (int i = 0; i < 300; i++) begin
      cyc(1, 16'(i), 0, 0);
      cyc(0, '0, 0, 1);
    end
    check("sat_drops", 32'(flush_drops), 32'd255);
    reset = 1'b1;
    cyc(1, 16'h77, 1, 1);
    reset = 1'b0;
    check("sat_rst_drops", 32'(flush_drops), 32'd0);
    check("sat_rst_ready", 32'(in_ready), 32'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      cyc($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0,
          $urandom_range(0, 39) == 0);
    end
    reset = 1'b0;
    cyc(0, '0, 1, 0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
